// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
// Shared definitions for the two-requester ALU arbiter:
//   - ALU command codes (3-bit) as seen on reqN_cmd / alu_command
//   - FSM state encoding of the arbiter sequencer
//   - bit positions inside rsp_flags
package alu_arbiter_pkg;

    // ALU command codes
    localparam logic [2:0] CMD_ADD  = 3'b000;
    localparam logic [2:0] CMD_SUB  = 3'b001;
    localparam logic [2:0] CMD_XOR  = 3'b010;
    localparam logic [2:0] CMD_SLT  = 3'b011;
    localparam logic [2:0] CMD_AND  = 3'b100;
    localparam logic [2:0] CMD_NAND = 3'b101;
    localparam logic [2:0] CMD_NOR  = 3'b110;
    localparam logic [2:0] CMD_OR   = 3'b111;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arbState_t;

    // rsp_flags bit positions
    localparam int FLAG_CARRY = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_OVF   = 2;

endpackage

// File: rtl/alu_arb_grant.sv
// alu_arb_grant
// Combinational two-way grant used by alu_arbiter while it is idle.
// Configuration macro: ALU_ARB_ROUND_ROBIN_EN
//   defined     -> on contention the requester not granted last wins
//   not defined -> fixed priority, requester 0 always wins contention
// Ports:
//   valid0, valid1  in   request present on requester 0 / 1
//   lastGrant       in   ID of the most recently accepted requester
//   grant0, grant1  out  one-hot (or zero) grant
//   grantId         out  ID of the granted requester (0 when none)
module alu_arb_grant (
    input  logic valid0,
    input  logic valid1,
    input  logic lastGrant,
    output logic grant0,
    output logic grant1,
    output logic grantId
);

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // Requester 1 wins when alone, or on contention when requester 0 was served last.
    assign grant1 = valid1 & (~valid0 | ~lastGrant);
    assign grant0 = valid0 & ~grant1;
`else
    logic unusedLastGrant;
    assign unusedLastGrant = lastGrant;
    assign grant0 = valid0;
    assign grant1 = valid1 & ~valid0;
`endif

    assign grantId = grant1;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one external combinational ALU between two requesters. A request is
// accepted in IDLE, the ALU is driven from the op registers during EXEC, the
// ALU result and flags are captured at the end of EXEC and held in RESP until
// the consumer takes them. One op takes at least 3 cycles.
// Configuration macro: ALU_ARB_ROUND_ROBIN_EN (see alu_arb_grant).
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. reqN_ready is combinational and only high in IDLE for the
// granted requester; requesters hold cmd/a/b stable while valid && !ready.
// rsp_valid comes from state RESP; rsp_* stay stable until rsp_ready.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   reqN_valid/ready/cmd/a/b    request channel of requester N (N = 0, 1)
//   alu_command, alu_a, alu_b   registered command/operands to the ALU
//   alu_result, alu_carryout,
//   alu_zero, alu_overflow      ALU outputs, captured at the end of EXEC
//   rsp_valid/ready             response handshake
//   rsp_id, rsp_result,
//   rsp_flags                   requester ID, result, {overflow, zero, carry}
//   dbgState                    current sequencer state (arbState_t encoding)
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_cmd,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_cmd,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [2:0]       alu_command,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [2:0]       rsp_flags,
    output logic [1:0]       dbgState
);

    arbState_t        state;
    arbState_t        nextState;
    logic             accept;
    logic             grant0;
    logic             grant1;
    logic             grantId;
    logic             lastGrant;
    logic [2:0]       opCmd;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             opId;
    logic             rspIdReg;
    logic [WIDTH-1:0] rspResultReg;
    logic [2:0]       rspFlagsReg;

    alu_arb_grant uGrant (
        .valid0    (req0_valid),
        .valid1    (req1_valid),
        .lastGrant (lastGrant),
        .grant0    (grant0),
        .grant1    (grant1),
        .grantId   (grantId)
    );

    // Next state and accept decision. Accept is masked by reset so no request
    // is acknowledged while the block is being reset.
    always_comb begin
        nextState = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!reset && (req0_valid || req1_valid)) begin
                    accept    = 1'b1;
                    nextState = ST_EXEC;
                end
            end
            ST_EXEC: nextState = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    nextState = ST_IDLE;
                end
            end
            default: nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            opCmd        <= 3'b000;
            opA          <= '0;
            opB          <= '0;
            opId         <= 1'b0;
            lastGrant    <= 1'b1;   // requester 0 wins the first contention
            rspIdReg     <= 1'b0;
            rspResultReg <= '0;
            rspFlagsReg  <= 3'b000;
        end else begin
            state <= nextState;
            if (accept) begin
                opCmd     <= grantId ? req1_cmd : req0_cmd;
                opA       <= grantId ? req1_a   : req0_a;
                opB       <= grantId ? req1_b   : req0_b;
                opId      <= grantId;
                lastGrant <= grantId;
            end
            if (state == ST_EXEC) begin
                rspIdReg                <= opId;
                rspResultReg            <= alu_result;
                rspFlagsReg[FLAG_CARRY] <= alu_carryout;
                rspFlagsReg[FLAG_ZERO]  <= alu_zero;
                rspFlagsReg[FLAG_OVF]   <= alu_overflow;
            end
        end
    end

    assign req0_ready  = accept & grant0;
    assign req1_ready  = accept & grant1;
    assign alu_command = opCmd;
    assign alu_a       = opA;
    assign alu_b       = opB;
    assign rsp_valid   = (state == ST_RESP);
    assign rsp_id      = rspIdReg;
    assign rsp_result  = rspResultReg;
    assign rsp_flags   = rspFlagsReg;
    assign dbgState    = state;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencing controller that shares one combinational 32-bit ALU between two requesters. It accepts operation requests through valid/ready handshakes and grants one requester at a time. It drives the ALU command and operands from registers, captures the result and flags, and returns them with a requester ID through a response handshake. It sits between the register-file/issue logic and the ALU built around the ALU control lookup table.

## Interface
- WIDTH, 32, operand/result width
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req0_valid / req1_valid  input  1  request present
- req0_ready / req1_ready  output  1  request accepted this cycle (combinational)
- req0_cmd / req1_cmd  input  3  ALU command: 000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 AND, 101 NAND, 110 NOR, 111 OR
- req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands
- alu_command  output  3  command to ALU
- alu_a, alu_b  output  WIDTH  operands to ALU
- alu_result  input  WIDTH  ALU result
- alu_carryout, alu_zero, alu_overflow  input  1  ALU flags
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  requester that issued the op (0 or 1)
- rsp_result  output  WIDTH  captured result
- rsp_flags  output  3  {overflow, zero, carryout} captured

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - if any reqN_valid, grant one requester and assert its reqN_ready this cycle.
  - latch its cmd, a, b and ID into op registers; next state EXEC.
  - with no valid request, stay in IDLE.
- EXEC: alu_command/alu_a/alu_b are driven from the op registers (this holds in every state). Capture alu_result and the flags into response registers at the end of the cycle; next state RESP.
- RESP:
  - rsp_valid=1; rsp_* stay stable until rsp_valid && rsp_ready, then next state IDLE.
  - reqN_ready=0 in EXEC and RESP.
- Only one reqN_ready may be high in any cycle; it is never high unless the matching reqN_valid is high.
- Grant when both valid: see Configuration. The last_grant register updates only on an accepted request.
- Requesters must hold cmd/a/b stable while valid and not ready; the arbiter samples them only in the accept cycle.

## Timing
- Accept in cycle N, ALU driven in N+1, rsp_valid first high in N+2.
- Minimum 3 cycles per op; peak throughput is 1 op / 3 cycles with rsp_ready tied high.
- rsp_ready low stalls in RESP indefinitely; no new request is accepted meanwhile.
- Reset values:
  - state IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=000.
  - alu_command=000, alu_a=alu_b=0, req0_ready=req1_ready=0.
  - last_grant=1, so req0 wins the first contention.
- Reset asserted mid-operation (EXEC or RESP) discards the transaction; no response is produced and the state is IDLE the next cycle.
- A request that goes valid in the same cycle rsp handshake completes is not accepted until the following cycle, which is in IDLE.

## Configuration
- ALU_ARB_ROUND_ROBIN_EN defined: when both requesters are valid in IDLE, grant the requester not granted last (alternates under continuous contention).
- Not defined: fixed priority, req0 always wins contention, and last_grant is unused. req1 starves while req0 stays valid.

## Structure
- The shared package/include holds:
  - ALU command code constants (ADD..OR, 3-bit).
  - FSM state encodings.
  - RSP_FLAGS bit positions (CARRY=0, ZERO=1, OVF=2).
- One natural sub-module, alu_arb_grant: a combinational two-way grant from valid0, valid1 and last_grant that returns grant0, grant1 and the grant ID. It holds the round-robin/fixed-priority choice under ALU_ARB_ROUND_ROBIN_EN.

## Test plan
- Reset: hold reset 2 cycles with both valids high -> both readys 0, rsp_valid 0, alu_command 000, alu_a=alu_b=0.
- Single ADD: req0 cmd=000, a=5, b=7 accepted at N -> rsp_valid at N+2, rsp_id=0, rsp_result=12, rsp_flags=000.
- Overflow SUB: req1 cmd=001, a=0x80000000, b=1 -> rsp_result=0x7FFFFFFF, rsp_id=1, overflow flag=1.
- Contention: both valid continuously with rsp_ready=1, four ops.
  - With macro: grant order 0,1,0,1.
  - Without macro: 0,0,0,0.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* unchanged, readys 0. On rsp_ready=1, back to IDLE and the next request is accepted the cycle after.
- Reset mid-EXEC: accept req0 SLT a=3 b=9, assert reset in EXEC -> no rsp_valid ever for that op, state IDLE, req0 re-accepted after reset deasserts.
